// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage of the RV32I core. Owns the PC, drives the byte address of the
//   instruction memory and captures the returned word into the IF/ID register
//   together with its PC and a valid bit. Supports stall, redirect (with flush)
//   and a sticky fetch fault for misaligned or out-of-range PCs.
//
// Ports
//   i_Clk          clock, all state on the rising edge
//   i_Rst          synchronous active-high reset
//   o_Addr         byte address to the instruction memory (the PC register)
//   i_Instruction  word returned by the instruction memory for o_Addr
//   i_Stall        hold PC and IF/ID register
//   i_Redirect     load PC from i_Target and flush IF/ID
//   i_Target       redirect byte address
//   o_Instruction  IF/ID instruction
//   o_PC           PC of o_Instruction
//   o_Valid        o_Instruction/o_PC hold a real fetched instruction
//   o_Fault        sticky fetch fault
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_HEIGHT = 256,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    output logic [31:0] o_Addr,
    input  logic [31:0] i_Instruction,
    input  logic        i_Stall,
    input  logic        i_Redirect,
    input  logic [31:0] i_Target,
    output logic [31:0] o_Instruction,
    output logic [31:0] o_PC,
    output logic        o_Valid,
    output logic        o_Fault
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_HEIGHT);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] fetch_pc_reg;
    logic        valid_reg;
    logic        fault_reg;
    logic        pc_bad;

    // A PC is unusable if it is not word aligned or lies beyond the memory.
    // A redirect target is deliberately not checked when it is loaded; it is
    // caught here on the following edge once it sits in pc_reg.
    assign pc_bad = (pc_reg[1:0] != 2'b00) || (pc_reg >= MEM_LIMIT);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP;
            fetch_pc_reg <= 32'h0000_0000;
            valid_reg    <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            case (state_reg)
                // One idle cycle so the memory sees RESET_PC before the
                // first capture into IF/ID.
                BOOT: begin
                    state_reg <= RUN;
                end
                RUN: begin
                    if (pc_bad && !i_Redirect) begin
                        // A redirect rescues a bad PC; otherwise lock up.
                        state_reg <= FAULT;
                        fault_reg <= 1'b1;
                        valid_reg <= 1'b0;
                        instr_reg <= NOP;
                    end else if (i_Redirect) begin
                        // Redirect wins over stall: the flushed slot cannot
                        // hold anything the downstream stage still needs.
                        pc_reg    <= i_Target;
                        instr_reg <= NOP;
                        valid_reg <= 1'b0;
                    end else if (!i_Stall) begin
                        instr_reg    <= i_Instruction;
                        fetch_pc_reg <= pc_reg;
                        valid_reg    <= 1'b1;
                        pc_reg       <= pc_reg + 32'd4;
                    end
                end
                FAULT: begin
                    // Terminal until reset; PC holds the faulting address.
                end
                default: begin
                    state_reg <= FAULT;
                    fault_reg <= 1'b1;
                    valid_reg <= 1'b0;
                    instr_reg <= NOP;
                end
            endcase
        end
    end

    assign o_Addr        = pc_reg;
    assign o_Instruction = instr_reg;
    assign o_PC          = fetch_pc_reg;
    assign o_Valid       = valid_reg;
    assign o_Fault       = fault_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Table-driven bench for instruction_fetch. Each record is one clock cycle of
//   stimulus plus the outputs expected right after that cycle's rising edge.
//   A small byte-addressed memory model answers o_Addr combinationally.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        i_Clk;
    logic        i_Rst;
    logic [31:0] o_Addr;
    logic [31:0] i_Instruction;
    logic        i_Stall;
    logic        i_Redirect;
    logic [31:0] i_Target;
    logic [31:0] o_Instruction;
    logic [31:0] o_PC;
    logic        o_Valid;
    logic        o_Fault;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        chk_pc;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_HEIGHT(256),
        .NOP       (NOP_WORD)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .o_Addr       (o_Addr),
        .i_Instruction(i_Instruction),
        .i_Stall      (i_Stall),
        .i_Redirect   (i_Redirect),
        .i_Target     (i_Target),
        .o_Instruction(o_Instruction),
        .o_PC         (o_PC),
        .o_Valid      (o_Valid),
        .o_Fault      (o_Fault)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Memory image: byte at address a is (a*37 + 11) mod 256.
    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] t;
        t = (a & 32'h0000_00FF) * 32'd37 + 32'd11;
        return t[7:0];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a >= 32'd256) return 32'h0000_0000;
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    assign i_Instruction = word_at(o_Addr);

    task automatic add(input logic rst, input logic stall, input logic redir,
                       input logic [31:0] target, input logic [31:0] addr,
                       input logic valid, input logic [31:0] pc, input logic chk_pc,
                       input logic [31:0] instr, input logic fault);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.target = target;
        v.addr = addr; v.valid = valid; v.pc = pc; v.chk_pc = chk_pc;
        v.instr = instr; v.fault = fault;
        vecs.push_back(v);
    endtask

    // Cycle that fetches the word at pc and moves the PC on by 4.
    task automatic add_adv(input logic [31:0] pc);
        add(0, 0, 0, 0, pc + 32'd4, 1, pc, 1, word_at(pc), 0);
    endtask

    // Reset cycle and the following BOOT cycle.
    task automatic add_reset(input logic stall);
        add(1, stall, 0, 0, 32'h0, 0, 32'h0, 1, NOP_WORD, 0);
        add(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, NOP_WORD, 0);
    endtask

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_Rst = 1'b1;
        i_Stall = 1'b0;
        i_Redirect = 1'b0;
        i_Target = 32'h0;

        // Reset, BOOT, then sequential fetch 0,4,8.
        add_reset(0);
        add_adv(32'h0);
        add_adv(32'h4);
        add_adv(32'h8);
        // Stall three cycles holding o_PC=8, then release.
        for (int k = 0; k < 3; k++)
            add(0, 1, 0, 0, 32'hC, 1, 32'h8, 1, word_at(32'h8), 0);
        add_adv(32'hC);
        // Redirect together with stall: flush then fetch the target.
        add(0, 1, 1, 32'h40, 32'h40, 0, 32'h0, 0, NOP_WORD, 0);
        add_adv(32'h40);
        // Misaligned redirect: flush, then fault; later redirect ignored.
        add(0, 0, 1, 32'h42, 32'h42, 0, 32'h0, 0, NOP_WORD, 0);
        add(0, 0, 0, 0, 32'h42, 0, 32'h0, 0, NOP_WORD, 1);
        add(0, 1, 1, 32'h0, 32'h42, 0, 32'h0, 0, NOP_WORD, 1);
        // Run off the end of memory.
        add_reset(0);
        add(0, 0, 1, 32'hF0, 32'hF0, 0, 32'h0, 0, NOP_WORD, 0);
        for (int k = 0; k < 4; k++)
            add_adv(32'hF0 + 32'(4 * k));
        add(0, 0, 0, 0, 32'h100, 0, 32'h0, 0, NOP_WORD, 1);
        add(0, 0, 0, 0, 32'h100, 0, 32'h0, 0, NOP_WORD, 1);
        // Reset mid-run at PC=0x20 while stalled.
        add_reset(0);
        for (int k = 0; k < 8; k++)
            add_adv(32'(4 * k));
        add_reset(1);
        add_adv(32'h0);
        // A redirect rescues a bad PC before it faults.
        add(0, 0, 1, 32'h81, 32'h81, 0, 32'h0, 0, NOP_WORD, 0);
        add(0, 0, 1, 32'h8, 32'h8, 0, 32'h0, 0, NOP_WORD, 0);
        add_adv(32'h8);
        // Out-of-range aligned target: fault wins over stall.
        add(0, 0, 1, 32'h104, 32'h104, 0, 32'h0, 0, NOP_WORD, 0);
        add(0, 1, 0, 0, 32'h104, 0, 32'h0, 0, NOP_WORD, 1);

        @(negedge i_Clk);
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            i_Rst      = vecs[i].rst;
            i_Stall    = vecs[i].stall;
            i_Redirect = vecs[i].redir;
            i_Target   = vecs[i].target;
            exp_q.push_back(vecs[i]);
            @(negedge i_Clk);
            e = exp_q.pop_front();
            $display("row %0d rst=%0b stall=%0b redir=%0b tgt=%h -> addr=%h pc=%h v=%0b instr=%h fault=%0b",
                     i, e.rst, e.stall, e.redir, e.target,
                     o_Addr, o_PC, o_Valid, o_Instruction, o_Fault);
            check("addr",  i, o_Addr, e.addr);
            check("valid", i, {31'b0, o_Valid}, {31'b0, e.valid});
            check("instr", i, o_Instruction, e.instr);
            check("fault", i, {31'b0, o_Fault}, {31'b0, e.fault});
            if (e.chk_pc)
                check("pc", i, o_PC, e.pc);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
